// File: rtl/sh7604_pkg.sv
// Shared SH7604 SCI types: serial mode register layout, receiver states and SSR bit positions.
package sh7604_pkg;

  typedef struct packed {
    logic       ca;
    logic       chr;
    logic       pe;
    logic       oe;
    logic       stop;
    logic       mp;
    logic [1:0] cks;
  } SMR_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    MPBIT  = 3'd4,
    STOP   = 3'd5
  } rx_state_t;

  localparam int SSR_TDRE = 7;
  localparam int SSR_RDRF = 6;
  localparam int SSR_ORER = 5;
  localparam int SSR_FER  = 4;
  localparam int SSR_PER  = 3;
  localparam int SSR_TEND = 2;
  localparam int SSR_MPB  = 1;
  localparam int SSR_MPBT = 0;

endpackage

// File: rtl/sh7604_sci_rx.sv
// SH7604 SCI asynchronous receiver: 16x oversampled frame decode, RDR load and SSR receive flags.
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge on the synchronised input
// START  | checking start bit at its midpoint, false start returns to IDLE
// DATA   | shifting data bits LSB first (7 or 8)
// PARITY | sampling the parity bit
// MPBIT  | sampling the multiprocessor bit
// STOP   | first stop bit; frame completes at its midpoint
module sh7604_sci_rx
  import sh7604_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       CE_16X,
  input  logic       RXD,
  input  logic [7:0] SMR,
  input  logic       RE,
  input  logic       RIE,
  input  logic       MPIE,
  input  logic       RDRF_CLR,
  input  logic       ORER_CLR,
  input  logic       FER_CLR,
  input  logic       PER_CLR,
  output logic [7:0] RDR,
  output logic       RDRF,
  output logic       ORER,
  output logic       FER,
  output logic       PER,
  output logic       MPB,
  output logic       MPIE_CLR,
  output logic       RXI,
  output logic       ERI
);

  SMR_t smr;
  assign smr = SMR_t'(SMR);

  logic unused_smr;
  assign unused_smr = ^{smr.ca, smr.stop, smr.cks};

  rx_state_t  state, state_nxt;
  logic [3:0] phase, phase_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;

  logic       rxd_s1, rxd_s2, rxd_last;
  logic [7:0] shreg;
  logic       par_acc, par_bit, mp_bit;

  logic       par_en, mp_en;
  logic [2:0] last_bit;
  logic       mid, start_go, frame_done;
  logic [7:0] rx_data;

  // MP overrides PE: the extra bit slot carries the MP bit, never parity
  assign mp_en    = smr.mp;
  assign par_en   = smr.pe & ~smr.mp;
  assign last_bit = smr.chr ? 3'd6 : 3'd7;
  assign mid      = CE_16X & RE & (phase == 4'd7);
  assign rx_data  = smr.chr ? {1'b0, shreg[7:1]} : shreg;

  always_comb begin
    state_nxt   = state;
    phase_nxt   = phase;
    bit_cnt_nxt = bit_cnt;
    start_go    = 1'b0;
    frame_done  = 1'b0;
    if (!RE) begin
      state_nxt   = IDLE;
      phase_nxt   = 4'd0;
      bit_cnt_nxt = 3'd0;
    end else if (CE_16X) begin
      if (state != IDLE) phase_nxt = phase + 4'd1;
      case (state)
        IDLE: begin
          if (rxd_last && !rxd_s2 && !ORER && !FER && !PER) begin
            state_nxt   = START;
            phase_nxt   = 4'd0;
            bit_cnt_nxt = 3'd0;
            start_go    = 1'b1;
          end
        end
        START: begin
          if (phase == 4'd7 && rxd_s2) begin
            state_nxt = IDLE;
            phase_nxt = 4'd0;
          end else if (phase == 4'd15) begin
            state_nxt = DATA;
          end
        end
        DATA: begin
          if (phase == 4'd15) begin
            if (bit_cnt == last_bit) begin
              if (par_en)     state_nxt = PARITY;
              else if (mp_en) state_nxt = MPBIT;
              else            state_nxt = STOP;
            end else begin
              bit_cnt_nxt = bit_cnt + 3'd1;
            end
          end
        end
        PARITY: begin
          if (phase == 4'd15) state_nxt = mp_en ? MPBIT : STOP;
        end
        MPBIT: begin
          if (phase == 4'd15) state_nxt = STOP;
        end
        STOP: begin
          if (phase == 4'd7) begin
            state_nxt  = IDLE;
            phase_nxt  = 4'd0;
            frame_done = 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          phase_nxt = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      phase   <= 4'd0;
      bit_cnt <= 3'd0;
    end else begin
      state   <= state_nxt;
      phase   <= phase_nxt;
      bit_cnt <= bit_cnt_nxt;
    end
  end

  logic discard, load, fer_set, per_set, rdrf_set, orer_set, mpie_hit;

  assign discard  = frame_done & mp_en & MPIE & ~mp_bit;
  assign orer_set = frame_done & ~discard & RDRF;
  assign load     = frame_done & ~discard & ~RDRF;
  assign fer_set  = load & ~rxd_s2;
  assign per_set  = load & par_en & ((par_acc ^ par_bit) != smr.oe);
  assign rdrf_set = load & ~fer_set & ~per_set;
  assign mpie_hit = frame_done & mp_en & MPIE & mp_bit;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rxd_s1   <= 1'b1;
      rxd_s2   <= 1'b1;
      rxd_last <= 1'b1;
      shreg    <= 8'h00;
      par_acc  <= 1'b0;
      par_bit  <= 1'b0;
      mp_bit   <= 1'b0;
      RDR      <= 8'h00;
      RDRF     <= 1'b0;
      ORER     <= 1'b0;
      FER      <= 1'b0;
      PER      <= 1'b0;
      MPB      <= 1'b0;
      MPIE_CLR <= 1'b0;
    end else begin
      rxd_s1 <= RXD;
      rxd_s2 <= rxd_s1;
      if (CE_16X) rxd_last <= rxd_s2;

      if (start_go) begin
        par_acc <= 1'b0;
        par_bit <= 1'b0;
        mp_bit  <= 1'b0;
      end else if (mid) begin
        case (state)
          DATA: begin
            shreg   <= {rxd_s2, shreg[7:1]};
            par_acc <= par_acc ^ rxd_s2;
          end
          PARITY:  par_bit <= rxd_s2;
          MPBIT:   mp_bit  <= rxd_s2;
          default: ;
        endcase
      end

      if (load) begin
        RDR <= rx_data;
        MPB <= mp_bit;
      end

      // set beats a coincident clear strobe
      RDRF     <= rdrf_set | (RDRF & ~RDRF_CLR);
      ORER     <= orer_set | (ORER & ~ORER_CLR);
      FER      <= fer_set  | (FER  & ~FER_CLR);
      PER      <= per_set  | (PER  & ~PER_CLR);
      MPIE_CLR <= mpie_hit;
    end
  end

  assign RXI = RIE & RDRF;
  assign ERI = RIE & (ORER | FER | PER);

endmodule

// File: tb/tb_sh7604_sci_rx.sv
// Self-checking bench for sh7604_sci_rx: table of frames plus hand-written corner sequences.
module tb_sh7604_sci_rx;

  logic       CLK = 1'b0;
  logic       RST, CE_16X, RXD;
  logic [7:0] SMR;
  logic       RE, RIE, MPIE;
  logic       RDRF_CLR, ORER_CLR, FER_CLR, PER_CLR;
  logic [7:0] RDR;
  logic       RDRF, ORER, FER, PER, MPB, MPIE_CLR, RXI, ERI;

  sh7604_sci_rx dut (
    .CLK(CLK), .RST(RST), .CE_16X(CE_16X), .RXD(RXD), .SMR(SMR),
    .RE(RE), .RIE(RIE), .MPIE(MPIE),
    .RDRF_CLR(RDRF_CLR), .ORER_CLR(ORER_CLR), .FER_CLR(FER_CLR), .PER_CLR(PER_CLR),
    .RDR(RDR), .RDRF(RDRF), .ORER(ORER), .FER(FER), .PER(PER), .MPB(MPB),
    .MPIE_CLR(MPIE_CLR), .RXI(RXI), .ERI(ERI)
  );

  always #5 CLK = ~CLK;

  initial begin
    int c;
    c = 0;
    CE_16X = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      c = (c + 1) % 4;
      CE_16X = (c == 0);
    end
  end

  int mpclr_cnt = 0;
  int rdrf_hi_cnt = 0;
  always @(negedge CLK) begin
    if (MPIE_CLR === 1'b1) mpclr_cnt++;
    if (RDRF === 1'b1) rdrf_hi_cnt++;
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         tag;
    logic [7:0] rdr;
    bit         rdrf, orer, fer, per, mpb;
    int         mpclr;
    int         mp_base;
  } exp_t;

  exp_t sb[$];

  task automatic push_exp(input int tag, input logic [7:0] rdr, input bit rdrf, input bit orer,
                          input bit fer, input bit per, input bit mpb, input int mpclr);
    exp_t e;
    e.tag = tag; e.rdr = rdr; e.rdrf = rdrf; e.orer = orer; e.fer = fer;
    e.per = per; e.mpb = mpb; e.mpclr = mpclr; e.mp_base = mpclr_cnt;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    @(negedge CLK);
    if (sb.size() == 0) begin
      cmp("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      cmp($sformatf("t%0d.rdr",  e.tag), {24'd0, RDR}, {24'd0, e.rdr});
      cmp($sformatf("t%0d.rdrf", e.tag), {31'd0, RDRF}, {31'd0, e.rdrf});
      cmp($sformatf("t%0d.orer", e.tag), {31'd0, ORER}, {31'd0, e.orer});
      cmp($sformatf("t%0d.fer",  e.tag), {31'd0, FER},  {31'd0, e.fer});
      cmp($sformatf("t%0d.per",  e.tag), {31'd0, PER},  {31'd0, e.per});
      cmp($sformatf("t%0d.mpb",  e.tag), {31'd0, MPB},  {31'd0, e.mpb});
      cmp($sformatf("t%0d.rxi",  e.tag), {31'd0, RXI},  {31'd0, RIE & e.rdrf});
      cmp($sformatf("t%0d.eri",  e.tag), {31'd0, ERI},  {31'd0, RIE & (e.orer | e.fer | e.per)});
      cmp($sformatf("t%0d.mpclr", e.tag), mpclr_cnt - e.mp_base, e.mpclr);
    end
  endtask

  function automatic logic [7:0] smr_byte(input bit chr, input bit pe, input bit oe, input bit mp);
    return {1'b0, chr, pe, oe, 1'b0, mp, 2'b00};
  endfunction

  task automatic clr_flags(input logic [3:0] m);
    @(posedge CLK); #1;
    {RDRF_CLR, ORER_CLR, FER_CLR, PER_CLR} = m;
    @(posedge CLK); #1;
    {RDRF_CLR, ORER_CLR, FER_CLR, PER_CLR} = 4'b0000;
  endtask

  task automatic drive_bit(input logic b);
    RXD = b;
    repeat (64) @(posedge CLK);
    #1;
  endtask

  // abort_kind: 0 none, 1 drop RE mid data bit 4, 2 pulse RST mid data bit 4
  task automatic send_frame(input logic [7:0] d, input bit chr, input bit par_on, input bit par_val,
                            input bit mp_on, input bit mp_val, input bit stop_val, input int abort_kind);
    int nb;
    nb = chr ? 7 : 8;
    drive_bit(1'b0);
    for (int i = 0; i < nb; i++) begin
      if (i == 4 && abort_kind != 0) begin
        RXD = d[i];
        repeat (32) @(posedge CLK);
        #1;
        if (abort_kind == 1) begin
          RE = 1'b0;
          repeat (32) @(posedge CLK);
        end else begin
          RST = 1'b1;
          repeat (2) @(posedge CLK);
          #1;
          RST = 1'b0;
          repeat (30) @(posedge CLK);
        end
        #1;
      end else begin
        drive_bit(d[i]);
      end
    end
    if (par_on) drive_bit(par_val);
    if (mp_on)  drive_bit(mp_val);
    drive_bit(stop_val);
    drive_bit(1'b1);
    RE = 1'b1;
    drive_bit(1'b1);
  endtask

  function automatic bit good_par(input logic [7:0] d, input bit chr, input bit oe);
    logic [7:0] m;
    m = chr ? (d & 8'h7F) : d;
    return (^m) ^ oe;
  endfunction

  typedef struct {
    bit chr, pe, oe, mp, mpie;
    logic [7:0] d;
    bit bad_par, mpbit, stop;
    logic [7:0] e_rdr;
    bit e_rdrf, e_orer, e_fer, e_per, e_mpb;
    int e_mpclr;
  } vec_t;

  localparam int NV = 11;
  vec_t vt [NV];

  initial begin
    #3ms;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    bit   par_on;
    int   base;

    //          chr pe oe mp mpie d      bad mpb stop  rdr  rdrf orer fer per mpb mpclr
    vt[0]  = '{0, 0, 0, 0, 0, 8'hA5, 0, 0, 1, 8'hA5, 1, 0, 0, 0, 0, 0};
    vt[1]  = '{1, 1, 1, 0, 0, 8'h35, 1, 0, 1, 8'h35, 0, 0, 0, 1, 0, 0};
    vt[2]  = '{0, 0, 0, 0, 0, 8'h7E, 0, 0, 0, 8'h7E, 0, 0, 1, 0, 0, 0};
    vt[3]  = '{0, 0, 0, 1, 1, 8'h40, 0, 0, 1, 8'h7E, 0, 0, 0, 0, 0, 0};
    vt[4]  = '{0, 0, 0, 1, 1, 8'h03, 0, 1, 1, 8'h03, 1, 0, 0, 0, 1, 1};
    vt[5]  = '{0, 1, 0, 0, 0, 8'h96, 0, 0, 1, 8'h96, 1, 0, 0, 0, 0, 0};
    vt[6]  = '{0, 1, 1, 0, 0, 8'h01, 0, 0, 1, 8'h01, 1, 0, 0, 0, 0, 0};
    vt[7]  = '{0, 1, 0, 1, 0, 8'h5A, 0, 0, 1, 8'h5A, 1, 0, 0, 0, 0, 0};
    vt[8]  = '{1, 0, 0, 0, 0, 8'hFF, 0, 0, 1, 8'h7F, 1, 0, 0, 0, 0, 0};
    vt[9]  = '{0, 0, 0, 1, 0, 8'hC3, 0, 1, 1, 8'hC3, 1, 0, 0, 0, 1, 0};
    vt[10] = '{1, 1, 0, 0, 0, 8'h2A, 0, 0, 1, 8'h2A, 1, 0, 0, 0, 0, 0};

    RST = 1'b1; RXD = 1'b1; SMR = 8'h00; RE = 1'b1; RIE = 1'b1; MPIE = 1'b0;
    {RDRF_CLR, ORER_CLR, FER_CLR, PER_CLR} = 4'b0000;
    repeat (5) @(posedge CLK);
    #1;
    RST = 1'b0;
    push_exp(0, 8'h00, 0, 0, 0, 0, 0, 0);
    check_pop();
    cmp("reset.mpie_clr", {31'd0, MPIE_CLR}, 32'd0);
    repeat (20) @(posedge CLK);
    #1;

    for (int k = 0; k < NV; k++) begin
      v = vt[k];
      SMR  = smr_byte(v.chr, v.pe, v.oe, v.mp);
      MPIE = v.mpie;
      clr_flags(4'b1111);
      par_on = v.pe && !v.mp;
      push_exp(10 + k, v.e_rdr, v.e_rdrf, v.e_orer, v.e_fer, v.e_per, v.e_mpb, v.e_mpclr);
      send_frame(v.d, v.chr, par_on, good_par(v.d, v.chr, v.oe) ^ v.bad_par,
                 v.mp, v.mpbit, v.stop, 0);
      check_pop();
    end
    MPIE = 1'b0;

    // overrun: two frames without clearing RDRF
    SMR = smr_byte(0, 0, 0, 0);
    clr_flags(4'b1111);
    push_exp(30, 8'h11, 1, 0, 0, 0, 0, 0);
    send_frame(8'h11, 0, 0, 0, 0, 0, 1, 0);
    check_pop();
    push_exp(31, 8'h11, 1, 1, 0, 0, 0, 0);
    send_frame(8'h22, 0, 0, 0, 0, 0, 1, 0);
    check_pop();

    // parity error blocks reception until PER is cleared
    SMR = smr_byte(1, 1, 1, 0);
    clr_flags(4'b1111);
    push_exp(40, 8'h35, 0, 0, 0, 1, 0, 0);
    send_frame(8'h35, 1, 1, good_par(8'h35, 1, 1) ^ 1'b1, 0, 0, 1, 0);
    check_pop();
    push_exp(41, 8'h35, 0, 0, 0, 1, 0, 0);
    send_frame(8'h44, 1, 1, good_par(8'h44, 1, 1), 0, 0, 1, 0);
    check_pop();
    clr_flags(4'b0001);
    push_exp(42, 8'h44, 1, 0, 0, 0, 0, 0);
    send_frame(8'h44, 1, 1, good_par(8'h44, 1, 1), 0, 0, 1, 0);
    check_pop();

    // RE dropped mid-frame: RDR and RDRF from the previous frame stay put
    SMR = smr_byte(0, 0, 0, 0);
    push_exp(50, 8'h44, 1, 0, 0, 0, 0, 0);
    send_frame(8'hF0, 0, 0, 0, 0, 0, 1, 1);
    check_pop();

    // RST mid-frame: everything back to reset values
    push_exp(51, 8'h00, 0, 0, 0, 0, 0, 0);
    send_frame(8'hF0, 0, 0, 0, 0, 0, 1, 2);
    check_pop();
    push_exp(52, 8'h5C, 1, 0, 0, 0, 0, 0);
    send_frame(8'h5C, 0, 0, 0, 0, 0, 1, 0);
    check_pop();

    // 6-tick glitch on idle line is a false start
    clr_flags(4'b1111);
    RXD = 1'b0;
    repeat (24) @(posedge CLK);
    #1;
    RXD = 1'b1;
    repeat (400) @(posedge CLK);
    #1;
    push_exp(60, 8'h5C, 0, 0, 0, 0, 0, 0);
    check_pop();
    push_exp(61, 8'hE7, 1, 0, 0, 0, 0, 0);
    send_frame(8'hE7, 0, 0, 0, 0, 0, 1, 0);
    check_pop();

    // RDRF_CLR held through completion: set wins for exactly one cycle
    clr_flags(4'b1111);
    base = rdrf_hi_cnt;
    RDRF_CLR = 1'b1;
    send_frame(8'h66, 0, 0, 0, 0, 0, 1, 0);
    RDRF_CLR = 1'b0;
    @(negedge CLK);
    cmp("collide.rdrf_cycles", rdrf_hi_cnt - base, 32'd1);
    cmp("collide.rdr", {24'd0, RDR}, 32'h66);

    // interrupts masked by RIE=0
    RIE = 1'b0;
    push_exp(70, 8'h77, 1, 0, 0, 0, 0, 0);
    send_frame(8'h77, 0, 0, 0, 0, 0, 1, 0);
    check_pop();
    cmp("rie0.rxi", {31'd0, RXI}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/sh7604_sci_rx.md
SH7604_SCI_RX -- requirements
Module: sh7604_sci_rx

Interface
REQ-001 SHALL have ports:
- CLK  in  1  system clock, single clock domain.
- RST  in  1  synchronous, active-high reset.
- CE_16X  in  1  16x-oversample tick from the external BRR baud generator, one CLK wide.
- RXD  in  1  asynchronous serial input, idle high.
- SMR  in  8  SMR_t; uses CHR, PE, OE, MP; CA must be 0 (async only).
- RE, RIE, MPIE  in  1 each  SCR bits.
- RDRF_CLR, ORER_CLR, FER_CLR, PER_CLR  in  1 each  one-cycle clear strobes from the SSR write-0 logic.
- RDR  out  8  receive data register.
- RDRF, ORER, FER, PER, MPB  out  1 each  SSR status bits.
- MPIE_CLR  out  1  one-cycle pulse to clear SCR.MPIE.
- RXI, ERI  out  1 each  interrupt requests to INTC.
REQ-002 SHALL register no parameters.

Function
REQ-003 SHALL synchronise RXD through two flip-flops before any use.
REQ-004 SHALL implement the states IDLE, START, DATA, PARITY, MPBIT and STOP, advancing only on CE_16X.
REQ-005 IDLE -> START on a synchronised falling edge of RXD, only when RE=1 and ORER=FER=PER=0; the 4-bit phase counter clears to 0 on entry.
REQ-006 Every state SHALL sample the line at phase 7, the bit midpoint, and advance at phase 15.
REQ-007 START SHALL return to IDLE if its midpoint sample is 1 (false start), and SHALL otherwise go to DATA.
REQ-008 DATA SHALL shift LSB-first, collecting 8 bits (CHR=0) or 7 bits (CHR=1, RDR[7]=0).
REQ-009 After DATA: go to PARITY if PE=1, else MPBIT if MP=1, else STOP; PARITY SHALL go to MPBIT if MP=1, else STOP.
REQ-010 Parity SHALL be even when OE=0 and odd when OE=1, computed over the data bits received.
REQ-011 PE and MP set together SHALL behave as MP only, with PE ignored.
REQ-012 Only the first stop bit SHALL be checked; SMR.STOP is ignored.
REQ-013 Completion occurs at the STOP midpoint (phase 7); the state returns to IDLE in the same cycle. Priority order:
- a) If MPIE=1 and the received MP bit is 0: discard the frame, leaving all flags and RDR unchanged.
- b) Else if RDRF=1: set ORER; RDR unchanged.
- c) Else: load RDR and MPB; set FER if the stop bit is 0; set PER if parity mismatches; set RDRF only if neither error is set.
- d) If MPIE=1 and MP bit=1: pulse MPIE_CLR.
REQ-014 The effects of REQ-013 SHALL be visible on the CLK edge following the sampling CE_16X (1-cycle latency).
REQ-015 When a clear strobe coincides with a set event on the same flag, the set SHALL win.
REQ-016 RE=0 SHALL force IDLE on the next CLK edge; flags and RDR are retained.
REQ-017 The outputs SHALL be RXI = RIE & RDRF and ERI = RIE & (ORER|FER|PER), combinational from the flags.
REQ-018 The phase counter SHALL wrap 15 -> 0 at each bit boundary; the bit counter SHALL be 3 bits and stop at the final data bit.

Reset
REQ-019 RST SHALL set state=IDLE, RDR=0x00, RDRF=ORER=FER=PER=MPB=0, MPIE_CLR=0, counters=0, and both synchroniser flops=1.
REQ-020 RST asserted mid-frame SHALL abandon the frame with no flag or RDR update.

Structure
REQ-021 The rx state enum and the SSR bit-index constants SHALL be added to SH7604_PKG; the module SHALL reuse SMR_t from that package.
REQ-022 SHALL be a single module with no sub-module; the baud generator and SSR register-file logic remain outside.

Verification
REQ-023 8N1 frame 0xA5 with CE_16X every 4 CLK -> RDR=0xA5, RDRF=1, FER=PER=0, RXI=1 with RIE=1.
REQ-024 CHR=1, PE=1, OE=1, data 0x35 with a bad parity bit -> RDR=0x35, PER=1, RDRF=0, ERI=1; a following frame is ignored until PER_CLR.
REQ-025 Two frames 0x11 then 0x22 without RDRF_CLR -> RDR=0x11, ORER=1 after the second frame.
REQ-026 Stop bit driven 0 on 0x7E -> FER=1, RDR=0x7E, RDRF=0; a 6-tick low glitch on idle RXD -> false start, no flags.
REQ-027 MP=1, MPIE=1: frame 0x40 with MP bit 0 -> no change; frame 0x03 with MP bit 1 -> RDR=0x03, MPB=1, RDRF=1, one MPIE_CLR pulse.
REQ-028 RE dropped at data bit 4, and separately RST asserted at data bit 4 -> IDLE, RDR and flags unchanged (RE case) or reset values (RST case); the next clean frame is received correctly.
